// File: rtl/sipo_pkg.sv
// Shared constants and sizing helper for the serial-in/parallel-out frame collector.
package sipo_pkg;
  localparam int N_DEF     = 4;
  localparam int WIDTH_DEF = 1;

  // Counter width for a 0..n-1 slice counter; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/sipo_frame_cnt.sv
// Slice position counter within a frame; wraps N-1 -> 0 and flags the last slice.
module sipo_frame_cnt
  import sipo_pkg::*;
#(
  parameter int  N  = N_DEF,
  localparam int CW = cnt_w(N)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          inc,
  input  logic          clr,
  output logic [CW-1:0] cnt,
  output logic          last
);

  logic [CW-1:0] cnt_d, cnt_q;

  assign last = (cnt_q == CW'(N - 1));
  assign cnt  = cnt_q;

  // A realign with a concurrent sample counts that sample as slice 0.
  always_comb begin
    cnt_d = cnt_q;
    if (clr)      cnt_d = inc ? CW'(1) : '0;
    else if (inc) cnt_d = last ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/sipo_collect.sv
// Collects N serial slices into a registered frame with a valid/ready output.
// Optional sticky overflow flag when SIPO_COLLECT_OVF_EN is defined.
module sipo_collect
  import sipo_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               en,
  input  logic [WIDTH-1:0]   si,
  input  logic               sync,
  output logic [N*WIDTH-1:0] dout,
  output logic               dvalid,
  input  logic               dready
`ifdef SIPO_COLLECT_OVF_EN
  ,
  output logic               ovf,
  input  logic               ovf_clr
`endif
);

  localparam int CW = cnt_w(N);

  logic [N-1:0][WIDTH-1:0] sr_d, sr_q;
  logic [N-1:0][WIDTH-1:0] dout_d, dout_q;
  logic                    dvalid_d, dvalid_q;
  logic [CW-1:0]           cnt;
  logic                    last;
  logic                    frame_done;
  logic                    load;

  sipo_frame_cnt #(.N(N)) u_cnt (
    .clk  (clk),
    .rstn (rstn),
    .inc  (en),
    .clr  (sync),
    .cnt  (cnt),
    .last (last)
  );

  // Realign wins over completion, so a sync edge never emits a frame.
  assign frame_done = en & last & ~sync;
  assign load       = frame_done & (~dvalid_q | dready);

  always_comb begin
    sr_d     = sr_q;
    dout_d   = dout_q;
    dvalid_d = dvalid_q;
    if (en) sr_d = {si, sr_q[N-1:1]};
    if (load) begin
      dout_d   = {si, sr_q[N-1:1]};
      dvalid_d = 1'b1;
    end else if (dvalid_q && dready) begin
      dvalid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sr_q     <= '0;
      dout_q   <= '0;
      dvalid_q <= 1'b0;
    end else begin
      sr_q     <= sr_d;
      dout_q   <= dout_d;
      dvalid_q <= dvalid_d;
    end
  end

  assign dout   = dout_q;
  assign dvalid = dvalid_q;

`ifdef SIPO_COLLECT_OVF_EN
  logic ovf_d, ovf_q;

  always_comb begin
    ovf_d = ovf_q;
    if (frame_done && dvalid_q && !dready) ovf_d = 1'b1;
    else if (ovf_clr)                      ovf_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) ovf_q <= 1'b0;
    else       ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;
`endif

  logic unused_cnt;
  assign unused_cnt = ^cnt;

endmodule

// File: tb/tb_sipo_collect.sv
// Directed plus randomized checks of sipo_collect against a queue-based frame model.
module tb_sipo_collect;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstn, en, si, sync, dready, dvalid;
  logic [3:0] dout;
  logic       en2, sync2, dready2, dvalid2;
  logic [7:0] si2;
  logic [15:0] dout2;
`ifdef SIPO_COLLECT_OVF_EN
  logic ovf, ovf_clr;
  logic movf;
`endif

  int checks = 0;
  int errors = 0;

  // Model: slices received since last realign, plus the held output frame.
  logic       q[$];
  logic [3:0] mdout;
  logic       mvalid;

  sipo_collect #(.N(4), .WIDTH(1)) u_dut (
    .clk(clk), .rstn(rstn), .en(en), .si(si), .sync(sync),
    .dout(dout), .dvalid(dvalid), .dready(dready)
`ifdef SIPO_COLLECT_OVF_EN
    , .ovf(ovf), .ovf_clr(ovf_clr)
`endif
  );

  sipo_collect #(.N(2), .WIDTH(8)) u_dut2 (
    .clk(clk), .rstn(rstn), .en(en2), .si(si2), .sync(sync2),
    .dout(dout2), .dvalid(dvalid2), .dready(dready2)
`ifdef SIPO_COLLECT_OVF_EN
    , .ovf(), .ovf_clr(1'b0)
`endif
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    mdout  = '0;
    mvalid = 1'b0;
`ifdef SIPO_COLLECT_OVF_EN
    movf = 1'b0;
`endif
  endtask

  task automatic model_edge();
    logic       comp;
    logic [3:0] frame;
    logic       was_valid;
    comp      = 1'b0;
    frame     = '0;
    was_valid = mvalid;
    if (sync) begin
      q.delete();
      if (en) q.push_back(si);
    end else if (en) begin
      q.push_back(si);
      if (q.size() == 4) begin
        comp = 1'b1;
        for (int k = 0; k < 4; k++) frame[k] = q[k];
        q.delete();
      end
    end
    if (comp && (!was_valid || dready)) begin
      mdout  = frame;
      mvalid = 1'b1;
    end else if (was_valid && dready) begin
      mvalid = 1'b0;
    end
`ifdef SIPO_COLLECT_OVF_EN
    if (comp && was_valid && !dready) movf = 1'b1;
    else if (ovf_clr)                 movf = 1'b0;
`endif
  endtask

  task automatic model_check(input string tag);
    chk({tag, ".dout"}, 16'(dout), 16'(mdout));
    chk({tag, ".dvalid"}, 16'(dvalid), 16'(mvalid));
`ifdef SIPO_COLLECT_OVF_EN
    chk({tag, ".ovf"}, 16'(ovf), 16'(movf));
`endif
  endtask

  task automatic step(input logic e, input logic s, input logic sy, input logic dr,
                      input logic oc, input string tag);
    en = e; si = s; sync = sy; dready = dr;
`ifdef SIPO_COLLECT_OVF_EN
    ovf_clr = oc;
`else
    if (oc) ;
`endif
    @(posedge clk);
    model_edge();
    #1;
    model_check(tag);
  endtask

  task automatic send_frame(input logic [3:0] v, input logic dr, input string tag);
    for (int k = 0; k < 4; k++) step(1'b1, v[k], 1'b0, dr, 1'b0, tag);
  endtask

  task automatic step2(input logic e, input logic [7:0] s, input logic [15:0] exp_d,
                       input logic exp_v, input string tag);
    en2 = e; si2 = s;
    @(posedge clk);
    #1;
    chk({tag, ".dout"}, dout2, exp_d);
    chk({tag, ".dvalid"}, 16'(dvalid2), 16'(exp_v));
  endtask

  initial begin
    rstn = 1'b0; en = 0; si = 0; sync = 0; dready = 0;
    en2 = 0; si2 = '0; sync2 = 0; dready2 = 1;
`ifdef SIPO_COLLECT_OVF_EN
    ovf_clr = 0;
`endif
    model_reset();
    #12;
    model_check("reset");
    chk("reset2.dout", dout2, 16'h0);
    @(negedge clk) rstn = 1'b1;

    // Wide slices with idle gaps between samples
    step2(1'b1, 8'h34, 16'h0000, 1'b0, "w8.s0");
    for (int g = 0; g < 3; g++) step2(1'b0, 8'hff, 16'h0000, 1'b0, "w8.gap");
    step2(1'b1, 8'h12, 16'h1234, 1'b1, "w8.done");
    step2(1'b0, 8'h00, 16'h1234, 1'b0, "w8.drain");

    // Basic frame, accepted immediately
    step(1, 1, 0, 1, 0, "basic"); step(1, 0, 0, 1, 0, "basic");
    step(1, 1, 0, 1, 0, "basic"); step(1, 1, 0, 1, 0, "basic");
    chk("basic.val", 16'(dout), 16'hd);
    step(0, 0, 0, 1, 0, "basic.drain");
    chk("basic.gone", 16'(dvalid), 16'h0);

    // Back-pressure: second frame is dropped
    send_frame(4'ha, 0, "bp.a");
    chk("bp.a.val", 16'(dout), 16'ha);
    send_frame(4'h5, 0, "bp.b");
    chk("bp.hold", 16'(dout), 16'ha);
`ifdef SIPO_COLLECT_OVF_EN
    chk("bp.ovf", 16'(ovf), 16'h1);
`endif
    step(0, 0, 0, 1, 0, "bp.drain");
    chk("bp.gone", 16'(dvalid), 16'h0);
    step(0, 0, 0, 0, 1, "bp.clr");

    // Realign mid-frame discards earlier slices
    step(1, 1, 0, 1, 0, "sync"); step(1, 1, 0, 1, 0, "sync");
    step(1, 0, 1, 1, 0, "sync"); step(1, 0, 0, 1, 0, "sync");
    step(1, 1, 0, 1, 0, "sync"); step(1, 0, 0, 1, 0, "sync");
    chk("sync.val", 16'(dout), 16'h4);
    step(0, 0, 0, 1, 0, "sync.drain");

    // Consume and complete on the same edge
    send_frame(4'h9, 0, "same.pre");
    step(1, 1, 0, 0, 0, "same"); step(1, 1, 0, 0, 0, "same");
    step(1, 0, 0, 0, 0, "same"); step(1, 0, 0, 1, 0, "same");
    chk("same.val", 16'(dout), 16'h3);
    chk("same.vld", 16'(dvalid), 16'h1);
    step(0, 0, 0, 1, 0, "same.drain");

    // Asynchronous reset mid-frame
    step(1, 1, 0, 0, 0, "mid"); step(1, 0, 0, 0, 0, "mid");
    #2 rstn = 1'b0;
    #1;
    model_reset();
    model_check("mid.rst");
    @(negedge clk) rstn = 1'b1;
    send_frame(4'b0001, 1, "mid.after");
    chk("mid.val", 16'(dout), 16'h1);

    // Randomized traffic
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom_range(0, 19) == 0),
           1'($urandom), 1'($urandom_range(0, 9) == 0), "rand");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
